// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA-3 input padding path.
package sha3_pkg;

    localparam int WORD_W = 64;
    localparam logic [WORD_W-1:0] PAD_END = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        PAD    = 2'd1,
        DONE   = 2'd2
    } pad_state_e;

endpackage

// File: rtl/padder1.sv
// Byte-level pad of the last message word: keeps the low byte_num bytes,
// places the 0x01 delimiter right after them and clears everything above.
module padder1
    import sha3_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [2:0]        byte_num,
    output logic [WORD_W-1:0] out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < byte_num) begin
                out[8*i +: 8] = in[8*i +: 8];
            end else if (3'(i) == byte_num) begin
                out[8*i +: 8] = 8'h01;
            end
        end
    end

endmodule

// File: rtl/sha3_block_padder.sv
// Assembles padded RATE_WORDS-word blocks from a 64-bit word stream and
// hands each block to the permutation with a full/ack handshake.
module sha3_block_padder
    import sha3_pkg::*;
#(
    parameter int RATE_WORDS = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            in,
    input  logic [2:0]                   byte_num,
    input  logic                         in_ready,
    input  logic                         is_last,
    output logic                         buffer_full,
    output logic [WORD_W*RATE_WORDS-1:0] out,
    output logic                         out_ready,
    input  logic                         f_ack
);

    localparam int BLOCK_W = WORD_W * RATE_WORDS;
    localparam int CNT_W   = $clog2(RATE_WORDS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RATE_WORDS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATE_WORDS - 1);

    pad_state_e          state;
    pad_state_e          state_next;
    logic [CNT_W-1:0]    count;
    logic [BLOCK_W-1:0]  block;
    logic [WORD_W-1:0]   padded_word;
    logic [WORD_W-1:0]   w;
    logic                shift_en;
    logic                terminated;
    logic                block_taken;

    padder1 u_padder1 (
        .in       (in),
        .byte_num (byte_num),
        .out      (padded_word)
    );

    assign buffer_full = (count == FULL_CNT);
    assign out_ready   = buffer_full;
    assign out         = block;
    assign block_taken = f_ack && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ACCEPT: begin
                if (in_ready && !buffer_full && is_last) begin
                    state_next = (count == LAST_SLOT) ? DONE : PAD;
                end
            end
            PAD: begin
                if (!buffer_full && count == LAST_SLOT) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = ACCEPT;
        endcase
    end

    // The word entering the block; the end marker is merged in whenever a
    // terminated message fills the last slot of the block.
    always_comb begin
        shift_en   = 1'b0;
        w          = '0;
        terminated = 1'b0;
        unique case (state)
            ACCEPT: begin
                shift_en   = in_ready && !buffer_full;
                w          = is_last ? padded_word : in;
                terminated = is_last;
            end
            PAD: begin
                shift_en   = !buffer_full;
                terminated = 1'b1;
            end
            default: begin
                shift_en = 1'b0;
            end
        endcase
        if (terminated && count == LAST_SLOT) begin
            w = w | PAD_END;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (block_taken) begin
            count <= '0;
        end else if (shift_en) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            block <= '0;
        end else if (shift_en) begin
            block <= {block[BLOCK_W-WORD_W-1:0], w};
        end
    end

endmodule

// File: tb/tb_sha3_block_padder.sv
// Self-checking bench for sha3_block_padder: a message-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sha3_block_padder;

    localparam int R  = 9;
    localparam int BW = 64 * R;
    localparam logic [63:0] END_BYTE = 64'h8000_0000_0000_0000;

    logic          clk;
    logic          reset;
    logic [63:0]   in_w;
    logic [2:0]    byte_num;
    logic          in_ready;
    logic          is_last;
    logic          buffer_full;
    logic [BW-1:0] dut_out;
    logic          out_ready;
    logic          f_ack;

    int checks = 0;
    int errors = 0;

    sha3_block_padder #(.RATE_WORDS(R)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_w),
        .byte_num    (byte_num),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .buffer_full (buffer_full),
        .out         (dut_out),
        .out_ready   (out_ready),
        .f_ack       (f_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the block is the last R words pushed, oldest on top.
    logic [63:0] hist[$];
    int          m_cnt = 0;
    bit          m_term = 0;
    bit          m_fin = 0;
    bit          m_push;
    logic [63:0] m_word;

    function automatic logic [63:0] padWord(input logic [63:0] d, input int n);
        logic [63:0] delim;
        delim = 64'h1 << (8 * n);
        return (d & (delim - 64'h1)) | delim;
    endfunction

    function automatic logic [BW-1:0] modelBlock();
        logic [BW-1:0] blk;
        int idx;
        blk = '0;
        for (int k = 0; k < R; k++) begin
            idx = hist.size() - R + k;
            if (idx >= 0) blk[64*(R-1-k) +: 64] = hist[idx];
        end
        return blk;
    endfunction

    function automatic logic [BW-1:0] packWords(input logic [63:0] ws[R]);
        logic [BW-1:0] blk;
        for (int k = 0; k < R; k++) blk[64*(R-1-k) +: 64] = ws[k];
        return blk;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            m_cnt  = 0;
            m_term = 0;
            m_fin  = 0;
        end else if (m_cnt == R && f_ack) begin
            m_cnt = 0;
        end else if (m_cnt < R && !m_fin) begin
            m_push = 0;
            m_word = '0;
            if (m_term) begin
                m_push = 1;
            end else if (in_ready) begin
                m_push = 1;
                m_word = is_last ? padWord(in_w, int'(byte_num)) : in_w;
                if (is_last) m_term = 1;
            end
            if (m_push) begin
                m_cnt++;
                if (m_term && m_cnt == R) begin
                    m_word = m_word | END_BYTE;
                    m_fin  = 1;
                end
                hist.push_back(m_word);
                if (hist.size() > R) void'(hist.pop_front());
            end
        end
    end

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_out", dut_out, modelBlock());
        checkValue("model_buffer_full", 64'(buffer_full), 64'(m_cnt == R));
        checkValue("model_out_ready", 64'(out_ready), 64'(m_cnt == R));
    end

    task automatic applyStimulus(input logic ir, input logic [63:0] d, input logic [2:0] bn,
                                 input logic last, input logic ack);
        in_ready = ir;
        in_w     = d;
        byte_num = bn;
        is_last  = last;
        f_ack    = ack;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, '0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic waitReady(input int budget, output int cycles);
        cycles = 0;
        while (!out_ready && cycles < budget) begin
            applyStimulus(0, '0, 0, 0, 0);
            cycles++;
        end
        if (!out_ready) checkValue("ready_timeout", 64'(out_ready), 64'h1);
    endtask

    logic [63:0] ws[R];
    logic [BW-1:0] saved_blk;
    int cyc;

    initial begin
        reset    = 1'b1;
        in_ready = 1'b0;
        in_w     = '0;
        byte_num = '0;
        is_last  = 1'b0;
        f_ack    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_out", dut_out, '0);
        checkValue("reset_ready", 64'(out_ready), 64'h0);
        checkValue("reset_full", 64'(buffer_full), 64'h0);

        // Empty message
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0);
        waitReady(20, cyc);
        checkValue("empty_latency", 64'(cyc + 1), 64'd9);
        checkValue("empty_top", dut_out[BW-1 -: 64], 64'h1);
        checkValue("empty_mid", 64'(dut_out[BW-65 : 64] == '0), 64'h1);
        checkValue("empty_low", dut_out[63:0], 64'h8000_0000_0000_0000);
        applyStimulus(0, '0, 0, 0, 1);
        checkValue("empty_ack_ready", 64'(out_ready), 64'h0);
        doReset();

        // "abc"
        applyStimulus(1, 64'h0000_0000_0063_6261, 3, 1, 0);
        waitReady(20, cyc);
        checkValue("abc_top", dut_out[BW-1 -: 64], 64'h0000_0000_0163_6261);
        checkValue("abc_low", dut_out[63:0], 64'h8000_0000_0000_0000);
        applyStimulus(0, '0, 0, 0, 1);
        doReset();

        // 8 full words then an empty last word in the final slot
        for (int i = 0; i < 8; i++) begin
            ws[i] = 64'hA000_0000_0000_0000 | 64'(i);
            applyStimulus(1, ws[i], 0, 0, 0);
        end
        ws[8] = 64'h8000_0000_0000_0001;
        checkValue("aligned_not_ready", 64'(out_ready), 64'h0);
        applyStimulus(1, 64'h1234_5678_9ABC_DEF0, 0, 1, 0);
        checkValue("aligned_ready", 64'(out_ready), 64'h1);
        checkValue("aligned_low", dut_out[63:0], 64'h8000_0000_0000_0001);
        saved_blk = packWords(ws);
        checkOutput("aligned_block", dut_out, saved_blk);
        applyStimulus(0, '0, 0, 0, 1);
        checkValue("aligned_ack_ready", 64'(out_ready), 64'h0);

        // Traffic after the final block is ignored
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 64'hDEAD_0000_0000_0000 | 64'(i), 3'd5, (i == 10), (i % 5 == 0));
            checkValue("done_ready", 64'(out_ready), 64'h0);
            checkOutput("done_out", dut_out, saved_blk);
        end
        doReset();

        // Back-pressure: word 10 held while the first block waits for ack
        for (int i = 0; i < R; i++) begin
            ws[i] = 64'hB000_0000_0000_0000 | 64'(i);
            applyStimulus(1, ws[i], 0, 0, 0);
        end
        applyStimulus(1, 64'hB000_0000_0000_0009, 0, 0, 0);
        checkValue("bp_full", 64'(buffer_full), 64'h1);
        checkOutput("bp_block", dut_out, packWords(ws));
        applyStimulus(1, 64'hB000_0000_0000_0009, 0, 0, 1);
        checkValue("bp_ack_ready", 64'(out_ready), 64'h0);
        applyStimulus(1, 64'hB000_0000_0000_0009, 0, 0, 0);
        checkValue("bp_word10", dut_out[63:0], 64'hB000_0000_0000_0009);
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_BBAA, 2, 1, 0);
        waitReady(20, cyc);
        ws[0] = 64'hB000_0000_0000_0009;
        ws[1] = 64'h0000_0000_0001_BBAA;
        for (int i = 2; i < R - 1; i++) ws[i] = '0;
        ws[R-1] = 64'h8000_0000_0000_0000;
        checkOutput("bp_block2", dut_out, packWords(ws));
        applyStimulus(0, '0, 0, 0, 1);

        // Reset mid-message drops everything
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 64'hC000_0000_0000_0000 | 64'(i), 0, 0, 0);
        doReset();
        checkOutput("midreset_out", dut_out, '0);
        checkValue("midreset_ready", 64'(out_ready), 64'h0);
        checkValue("midreset_full", 64'(buffer_full), 64'h0);
        for (int i = 0; i < R; i++) begin
            ws[i] = 64'hD000_0000_0000_0000 | 64'(i);
            applyStimulus(1, ws[i], 0, 0, 0);
        end
        checkValue("midreset_ready2", 64'(out_ready), 64'h1);
        checkOutput("midreset_block", dut_out, packWords(ws));
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
